// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32I load/store port.
//   Accepts one access per request, optionally inserts WAIT_CYCLES wait
//   states, then commits (byte-masked store or sign/zero-extended load)
//   on the edge entering RESP and raises d_ready for one cycle.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   d_req               request, sampled only in IDLE
//   d_wr_en/d_func3     store flag and RV32I funct3, captured with d_req
//   d_addr/d_wdata      byte address and LSB-aligned store data
//   d_rdata             extended load data, qualified by d_ready
//   d_ready             one-cycle response pulse
//   d_misalign          error flag, qualified by d_ready
//   d_err_sticky        (only with DMEM_ERR_STICKY_EN) latched error flag
// Optional feature macro: DMEM_ERR_STICKY_EN
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_req,
    input  logic        d_wr_en,
    input  logic [2:0]  d_func3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_misalign
`ifdef DMEM_ERR_STICKY_EN
    ,
    output logic        d_err_sticky
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    // With no wait states the commit coincides with the accept edge, so the
    // live request inputs are used instead of the (not yet loaded) capture regs.
    logic        acc_wr;
    logic [2:0]  acc_f3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    always_comb begin
        if (state == IDLE) begin
            acc_wr    = d_wr_en;
            acc_f3    = d_func3;
            acc_addr  = d_addr;
            acc_wdata = d_wdata;
        end else begin
            acc_wr    = wr_q;
            acc_f3    = f3_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    logic commit;
    assign commit = ((state == IDLE) && d_req && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == LAST));

    logic [ADDR_W-1:0] idx;
    logic [31:0]       word;
    assign idx  = acc_addr[ADDR_W+1:2];
    assign word = mem[idx];

    // Upper address bits alias; they are intentionally dropped.
    logic unused_addr;
    assign unused_addr = &{1'b0, acc_addr[31:ADDR_W+2]};

    logic f3_ok, mis, err;
    always_comb begin
        if (acc_wr) f3_ok = acc_f3 inside {3'd0, 3'd1, 3'd2};
        else        f3_ok = acc_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        mis = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
              ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
        err = !f3_ok || mis;
    end

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;
    always_comb begin
        byte_v = word[{acc_addr[1:0], 3'b000} +: 8];
        half_v = word[{acc_addr[1], 4'b0000} +: 16];
        case (acc_f3)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b010:  load_v = word;
            3'b100:  load_v = {24'd0, byte_v};
            3'b101:  load_v = {16'd0, half_v};
            default: load_v = 32'd0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the lanes.
    logic [3:0]  be;
    logic [31:0] wd;
    always_comb begin
        be = 4'b0000;
        wd = acc_wdata;
        case (acc_f3)
            3'b000: begin be = 4'b0001 << acc_addr[1:0]; wd = {4{acc_wdata[7:0]}}; end
            3'b001: begin be = acc_addr[1] ? 4'b1100 : 4'b0011; wd = {2{acc_wdata[15:0]}}; end
            3'b010: begin be = 4'b1111; wd = acc_wdata; end
            default: be = 4'b0000;
        endcase
    end

    // RAM is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && acc_wr && !err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            d_ready    <= 1'b0;
            d_rdata    <= 32'd0;
            d_misalign <= 1'b0;
        end else begin
            d_ready <= 1'b0;
            if (commit) begin
                d_ready    <= 1'b1;
                d_misalign <= err;
                if (err)         d_rdata <= 32'd0;
                else if (!acc_wr) d_rdata <= load_v;
            end
            case (state)
                IDLE: if (d_req) begin
                    wr_q    <= d_wr_en;
                    f3_q    <= d_func3;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    cnt     <= 4'd0;
                    state   <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
                WAIT: if (cnt == LAST) state <= RESP;
                      else cnt <= cnt + 4'd1;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ERR_STICKY_EN
    always_ff @(posedge clk) begin
        if (reset)                        d_err_sticky <= 1'b0;
        else if (d_ready && d_misalign)   d_err_sticky <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives two responders (WAIT_CYCLES=0 as u0, =3 as u1)
// and compares them with a byte-level memory model.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst0, rst1, req, wr, sel;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, mis0, mis1;
    logic        rdy;
    logic [31:0] rdc;
    assign rdy = sel ? rdy1 : rdy0;
    assign rdc = sel ? rd1 : rd0;
`ifdef DMEM_ERR_STICKY_EN
    logic st0, st1;
`endif

    int checks = 0, failures = 0;
    bit [31:0] model [2][256];

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(rst0), .d_req(req && !sel), .d_wr_en(wr), .d_func3(f3),
        .d_addr(addr), .d_wdata(wdata), .d_rdata(rd0), .d_ready(rdy0), .d_misalign(mis0)
`ifdef DMEM_ERR_STICKY_EN
        , .d_err_sticky(st0)
`endif
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .reset(rst1), .d_req(req && sel), .d_wr_en(wr), .d_func3(f3),
        .d_addr(addr), .d_wdata(wdata), .d_rdata(rd1), .d_ready(rdy1), .d_misalign(mis1)
`ifdef DMEM_ERR_STICKY_EN
        , .d_err_sticky(st1)
`endif
    );

    // Reference: access size from funct3, legality, alignment, then byte math.
    function automatic void ref_access(input int d, input bit w, input bit [2:0] f,
                                       input bit [31:0] a, input bit [31:0] wd,
                                       output bit [31:0] rd, output bit m);
        int sz, off, idx;
        bit ok;
        bit [31:0] wv, mask;
        sz  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        idx = int'((a / 4) % 256);
        ok  = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
        m   = !ok || ((a % sz) != 0);
        rd  = 32'd0;
        if (m) return;
        wv   = model[d][idx];
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        if (w) begin
            wv = (wv & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            model[d][idx] = wv;
        end else begin
            rd = (wv >> (8 * off)) & mask;
            if (!f[2] && sz < 4 && rd[8 * sz - 1]) rd = rd | ~mask;
        end
    endfunction

    // Runs one access on DUT s and returns what it saw plus the model's view.
    task automatic xact(input bit s, input bit w, input bit [2:0] f, input bit [31:0] a,
                        input bit [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic m, output bit pok, output bit [31:0] erd, output bit em);
        int rc;
        @(negedge clk);
        sel = s; req = 1'b1; wr = w; f3 = f; addr = a; wdata = wd; rc = cyc;
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < 40 && !rdy; k++) begin @(posedge clk); #1; end
        lat = cyc - rc;
        rd  = rdc;
        m   = s ? mis1 : mis0;
        @(posedge clk); #1;
        pok = !rdy && (rdc === rd);   // single-cycle pulse, data held afterwards
        ref_access(s ? 1 : 0, w, f, a, wd, erd, em);
    endtask

    task automatic test_reset;
        checks++;
        if ({rdy0, mis0, rd0} !== 34'd0 || {rdy1, mis1, rd1} !== 34'd0) begin
            failures++;
            $display("FAIL reset: u0 rdy/mis/rd=%b/%b/%h u1=%b/%b/%h, want all 0", rdy0, mis0, rd0, rdy1, mis1, rd1);
        end
`ifdef DMEM_ERR_STICKY_EN
        checks++;
        if ({st0, st1} !== 2'b00) begin
            failures++; $display("FAIL reset_sticky: got %b%b want 00", st0, st1);
        end
`endif
    endtask

    task automatic test_fill;
        int lat, bad; logic [31:0] rd; logic m; bit pok, em; bit [31:0] erd;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            xact(0, 1, 3'd2, ($urandom_range(0, 7) << 10) | (i * 4), $urandom(), lat, rd, m, pok, erd, em);
            if (lat !== 1 || m !== 1'b0 || !pok) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL fill: %0d of 256 stores had wrong latency/flag, want 0", bad);
        end
    endtask

    typedef struct { bit w; bit [2:0] f; bit [31:0] a; bit [31:0] wd; bit [31:0] want; bit em; bit chk; } op_t;

    task automatic test_rv32_access;
        op_t ops[14];
        int lat; logic [31:0] rd; logic m; bit pok, em; bit [31:0] erd;
        ops = '{
            '{1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0},
            '{0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1},
            '{1, 3'd0, 32'h11, 32'h80,       32'h0,        0, 0},
            '{0, 3'd0, 32'h11, 32'h0,        32'hFFFFFF80, 0, 1},
            '{0, 3'd4, 32'h11, 32'h0,        32'h00000080, 0, 1},
            '{0, 3'd2, 32'h10, 32'h0,        32'hDEAD80EF, 0, 1},
            '{1, 3'd1, 32'h22, 32'h8001,     32'h0,        0, 0},
            '{0, 3'd1, 32'h22, 32'h0,        32'hFFFF8001, 0, 1},
            '{0, 3'd5, 32'h22, 32'h0,        32'h00008001, 0, 1},
            '{0, 3'd2, 32'h20, 32'h0,        32'h0,        0, 0},
            '{1, 3'd2, 32'h13, 32'h12345678, 32'h0,        1, 1},
            '{0, 3'd2, 32'h10, 32'h0,        32'hDEAD80EF, 0, 1},
            '{0, 3'd1, 32'h01, 32'h0,        32'h0,        1, 1},
            '{0, 3'd3, 32'h10, 32'h0,        32'h0,        1, 1}
        };
        for (int i = 0; i < 14; i++) begin
            xact(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, lat, rd, m, pok, erd, em);
            checks++;
            if (lat !== 1 || m !== ops[i].em || em !== ops[i].em || !pok ||
                (ops[i].chk && rd !== ops[i].want) || ((!ops[i].w || em) && rd !== erd)) begin
                failures++;
                $display("FAIL access[%0d] f3=%0d a=%h: lat=%0d mis=%b rd=%h pulse_ok=%b, want lat=1 mis=%b rd=%h",
                         i, ops[i].f, ops[i].a, lat, m, rd, pok, ops[i].em, ops[i].chk ? ops[i].want : erd);
            end
            if (i == 9) begin
                checks++;
                if (rd[31:16] !== 16'h8001) begin
                    failures++; $display("FAIL lw_0x20_upper: got %h want 8001", rd[31:16]);
                end
            end
        end
`ifdef DMEM_ERR_STICKY_EN
        checks++;
        if (st0 !== 1'b1) begin failures++; $display("FAIL sticky_set: got %b want 1", st0); end
        repeat (3) begin
            xact(0, 0, 3'd2, 32'h10, 32'h0, lat, rd, m, pok, erd, em);
            checks++;
            if (st0 !== 1'b1) begin failures++; $display("FAIL sticky_hold: got %b want 1", st0); end
        end
        @(negedge clk); rst0 = 1'b1; @(negedge clk); rst0 = 1'b0;
        checks++;
        if (st0 !== 1'b0) begin failures++; $display("FAIL sticky_clear: got %b want 0", st0); end
`endif
    endtask

    task automatic test_random;
        int lat; logic [31:0] rd; logic m; bit pok, em, w; bit [31:0] erd, a; bit [2:0] f;
        for (int i = 0; i < 200; i++) begin
            w = ($urandom_range(0, 2) == 0);
            f = 3'($urandom_range(0, 7));
            a = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            xact(0, w, f, a, $urandom(), lat, rd, m, pok, erd, em);
            checks++;
            if (lat !== 1 || m !== em || !pok || ((!w || em) && rd !== erd)) begin
                failures++;
                $display("FAIL random[%0d] w=%0b f3=%0d a=%h: lat=%0d mis=%b rd=%h pulse_ok=%b, want lat=1 mis=%b rd=%h",
                         i, w, f, a, lat, m, rd, pok, em, erd);
            end
        end
    endtask

    task automatic test_wait_states;
        int lat, rc, first, second, nrdy; logic [31:0] rd, rfirst; logic m, mfirst; bit pok, em; bit [31:0] erd;
        xact(1, 1, 3'd2, 32'h40, 32'hA5A5_5A5A, lat, rd, m, pok, erd, em);
        checks++;
        if (lat !== 4 || m !== 1'b0 || !pok) begin
            failures++; $display("FAIL wait_sw: lat=%0d mis=%b pulse_ok=%b, want 4/0/1", lat, m, pok);
        end
        // Hold d_req high: it must be ignored in WAIT/RESP.
        @(negedge clk);
        sel = 1'b1; req = 1'b1; wr = 1'b0; f3 = 3'd2; addr = 32'h40; wdata = 32'h0; rc = cyc;
        first = -1; second = -1; nrdy = 0; rfirst = 32'h0; mfirst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rdy1) begin
                nrdy++;
                if (first < 0) begin first = cyc; rfirst = rd1; mfirst = mis1; end
                else if (second < 0) second = cyc;
            end
        end
        req = 1'b0;
        ref_access(1, 0, 3'd2, 32'h40, 32'h0, erd, em);
        checks++;
        if (first !== rc + 4 || rfirst !== erd || mfirst !== 1'b0) begin
            failures++; $display("FAIL wait_lw: ready at +%0d rd=%h mis=%b, want +4 rd=%h mis=0", first - rc, rfirst, mfirst, erd);
        end
        checks++;
        if (second !== rc + 9 || nrdy !== 2) begin
            failures++; $display("FAIL wait_throughput: 2nd ready at +%0d count=%0d, want +9 count=2", second - rc, nrdy);
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_abort;
        int lat, seen; logic [31:0] rd; logic m; bit pok, em; bit [31:0] erd;
        xact(1, 1, 3'd2, 32'h80, 32'h1357_9BDF, lat, rd, m, pok, erd, em);
        xact(1, 0, 3'd6, 32'h80, 32'h0, lat, rd, m, pok, erd, em);
        checks++;
        if (m !== 1'b1 || rd !== 32'h0 || lat !== 4) begin
            failures++; $display("FAIL wait_badf3: mis=%b rd=%h lat=%0d, want 1/0/4", m, rd, lat);
        end
        xact(1, 0, 3'd2, 32'h80, 32'h0, lat, rd, m, pok, erd, em);
        checks++;
        if (rd !== 32'h1357_9BDF || m !== 1'b0) begin
            failures++; $display("FAIL wait_lw80: rd=%h mis=%b, want 13579bdf/0", rd, m);
        end
`ifdef DMEM_ERR_STICKY_EN
        checks++;
        if (st1 !== 1'b1) begin failures++; $display("FAIL sticky_u1: got %b want 1", st1); end
`endif
        @(negedge clk);
        sel = 1'b1; req = 1'b1; wr = 1'b1; f3 = 3'd2; addr = 32'h80; wdata = 32'hFFFF_0000;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk);
        @(negedge clk); rst1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rdy1, mis1, rd1} !== 34'd0) begin
            failures++; $display("FAIL abort_outputs: rdy=%b mis=%b rd=%h, want 0/0/0", rdy1, mis1, rd1);
        end
`ifdef DMEM_ERR_STICKY_EN
        checks++;
        if (st1 !== 1'b0) begin failures++; $display("FAIL abort_sticky: got %b want 0", st1); end
`endif
        @(negedge clk); rst1 = 1'b0;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (rdy1) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL abort_noresp: %0d ready pulses, want 0", seen); end
        xact(1, 0, 3'd2, 32'h80, 32'h0, lat, rd, m, pok, erd, em);
        checks++;
        if (rd !== 32'h1357_9BDF || rd !== erd) begin
            failures++; $display("FAIL abort_readback: rd=%h want 13579bdf", rd);
        end
        xact(1, 1, 3'd2, 32'h400, 32'hC0FF_EE00, lat, rd, m, pok, erd, em);
        xact(1, 0, 3'd2, 32'h000, 32'h0, lat, rd, m, pok, erd, em);
        checks++;
        if (rd !== 32'hC0FF_EE00 || rd !== erd || lat !== 4) begin
            failures++; $display("FAIL alias: rd=%h lat=%0d, want c0ffee00 lat=4", rd, lat);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; req = 1'b0; wr = 1'b0; sel = 1'b0;
        f3 = 3'd0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst0 = 1'b0; rst1 = 1'b0;
        test_reset();
        test_fill();
        test_rv32_access();
        test_random();
        test_wait_states();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
